psram_req_arbiter: RTL
======================

Name: psram_req_arbiter

Overview:
- Shares one EF_PSRAM_CTRL native transaction port between two requesters: m0 (CPU/AHB bridge) and m1 (DMA).
- Sits between the requesters and the PSRAM controller core; only one QSPI transaction is outstanding at a time.
- Supports round-robin or fixed-priority arbitration, with a starvation guard for m1.
- Latches the winning request, issues it as a single-cycle start pulse, and routes done/rdata back to the owner.

Parameters:
- AW, 24, PSRAM byte-address width.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority with m0 highest.
- STARVE_LIMIT, 4, in PRIO_MODE=1, number of consecutive m0 grants while m1 waits before m1 is forced. Range 1..15.

Ports:
- HCLK  input  1  clock.
- HRESET  input  1  asynchronous, active-high reset.
- m0_req  input  1  m0 request; level, held until m0_done.
- m0_addr  input  AW  m0 byte address.
- m0_wr  input  1  1 = write.
- m0_size  input  2  0 = byte, 1 = half, 2 = word.
- m0_wdata  input  32  m0 write data.
- m0_done  output  1  one-cycle completion pulse.
- m0_rdata  output  32  read data, valid with m0_done.
- m1_*  (same set as m0)  m1 request interface.
- s_start  output  1  one-cycle start to controller.
- s_addr  output  AW  latched address.
- s_wr  output  1  latched direction.
- s_size  output  2  latched size.
- s_wdata  output  32  latched write data.
- s_done  input  1  controller completion pulse.
- s_rdata  input  32  controller read data, valid with s_done.
- busy  output  1  transaction in flight.
- owner  output  1  current or last grantee.

Behaviour:
- Reset values: s_start=0, s_addr=0, s_wr=0, s_size=0, s_wdata=0, m0_done=0, m1_done=0, m0_rdata=0, m1_rdata=0, busy=0, owner=0, starve_cnt=0, rr_last=1 (so m0 wins the first tie).
- FSM states:
  - IDLE: if any req, select winner, latch its addr/wr/size/wdata into the s_* registers, set owner, go to ISSUE.
  - ISSUE: s_start=1 for exactly this cycle; go to WAIT.
  - WAIT: on s_done, capture s_rdata into the owner's rdata register, pulse the owner's done next cycle, go to DONE.
  - DONE: done pulse visible this cycle; go to IDLE.
- Latency: req sampled in IDLE at cycle N; s_start at N+1; s_done at cycle K; mX_done at K+1. Minimum 3 cycles of arbitration overhead per transaction, with no back-to-back overlap.
- busy=1 in ISSUE, WAIT and DONE.
- s_* fields hold stable from ISSUE until DONE exits. Requester inputs are ignored while busy.
- Round-robin (PRIO_MODE=0): with both requesting, grant !rr_last; rr_last updates on each grant.
- Fixed priority (PRIO_MODE=1): m0 wins a tie. starve_cnt increments on each m0 grant made while m1_req=1. When starve_cnt==STARVE_LIMIT, m1 wins the next tie. starve_cnt clears on any m1 grant, or on an m0 grant with m1_req=0. starve_cnt saturates, never wraps.
- Single requester: always granted, regardless of mode.
- Requester drops req while its own transaction is in flight: the transaction still completes and the done pulse is still issued. Requesters must not do this (protocol violation), but the arbiter must not hang.
- s_done outside WAIT: ignored.
- s_done in the same cycle as state entry to WAIT: legal, handled normally.
- HRESET mid-transaction: all state returns to reset values immediately, with no done pulse. The PSRAM controller is reset by the same HRESET, so no orphaned transaction remains.
- m*_rdata holds its value until that requester's next read completes.

Decomposition:
- Package psram_arb_pkg:
  - FSM state encoding (IDLE, ISSUE, WAIT, DONE).
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - Default STARVE_LIMIT constant.
- Sub-module psram_arb_sel: combinational winner select plus registered rr_last/starve_cnt, producing grant[1:0]. The top module owns the FSM, the latches and the response routing.

Test Plan:
- Single m0 word write (addr 0x000000, 0xABCD1234) → s_start 1 cycle after req with s_wr=1, s_size=2; after s_done, m0_done pulses once and m1_done stays 0.
- Both requesting continuously, PRIO_MODE=0, 4 transactions → grants alternate m0, m1, m0, m1.
- PRIO_MODE=1, STARVE_LIMIT=2, both requesting continuously → grants m0, m0, m1, m0, m0, m1.
- m1 byte read at addr 100 with s_rdata=0x88776655 → m1_rdata=0x88776655 with m1_done; m0_rdata unchanged.
- HRESET asserted in WAIT → busy, s_start and the done outputs are 0 in the same cycle; after release, a new m0 request issues normally.
- s_done injected in IDLE → no done pulse and no state change.

Source files
------------

// File: rtl/psram_arb_pkg.sv
// Shared definitions for the two-master PSRAM transaction arbiter.
// Covers the FSM encoding, access-size codes and the default starvation limit.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/psram_arb_sel.sv
// Winner selection for the PSRAM arbiter: round-robin or fixed priority with an m1 starvation guard.
// Grant is combinational; history (rr_last, starve_cnt) only advances when the top takes the grant.
module psram_arb_sel
  import psram_arb_pkg::*;
#(
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       rr_last_q, rr_last_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (PRIO_MODE == 0) begin
          grant = rr_last_q ? 2'b01 : 2'b10;
        end else begin
          grant = (starve_cnt_q == LIMIT) ? 2'b10 : 2'b01;
        end
      end
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    rr_last_d    = rr_last_q;
    starve_cnt_d = starve_cnt_q;
    if (take && (grant != 2'b00)) begin
      rr_last_d = grant[1];
      if (PRIO_MODE != 0) begin
        // Only m0 wins made while m1 is waiting count towards forcing m1.
        if (grant[1]) begin
          starve_cnt_d = 4'd0;
        end else if (req[1]) begin
          starve_cnt_d = (starve_cnt_q >= LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end else begin
          starve_cnt_d = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q    <= 1'b1;
      starve_cnt_q <= 4'd0;
    end else begin
      rr_last_q    <= rr_last_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/psram_req_arbiter.sv
// Shares one PSRAM controller transaction port between a CPU master (m0) and a DMA master (m1).
// One transaction at a time: latch winner, pulse s_start, wait for s_done, pulse the owner's done.
module psram_req_arbiter
  import psram_arb_pkg::*;
#(
  parameter int AW           = 24,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_wr,
  input  logic [1:0]    m0_size,
  input  logic [31:0]   m0_wdata,
  output logic          m0_done,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_wr,
  input  logic [1:0]    m1_size,
  input  logic [31:0]   m1_wdata,
  output logic          m1_done,
  output logic [31:0]   m1_rdata,
  output logic          s_start,
  output logic [AW-1:0] s_addr,
  output logic          s_wr,
  output logic [1:0]    s_size,
  output logic [31:0]   s_wdata,
  input  logic          s_done,
  input  logic [31:0]   s_rdata,
  output logic          busy,
  output logic          owner
);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic          s_wr_q, s_wr_d;
  logic [1:0]    s_size_q, s_size_d;
  logic [31:0]   s_wdata_q, s_wdata_d;
  logic          owner_q, owner_d;
  logic          m0_done_q, m0_done_d;
  logic          m1_done_q, m1_done_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       take;

  assign req = {m1_req, m0_req};

  psram_arb_sel #(
    .PRIO_MODE    (PRIO_MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .clk   (HCLK),
    .rst   (HRESET),
    .req   (req),
    .take  (take),
    .grant (grant)
  );

  always_comb begin
    state_d    = state_q;
    s_addr_d   = s_addr_q;
    s_wr_d     = s_wr_q;
    s_size_d   = s_size_q;
    s_wdata_d  = s_wdata_q;
    owner_d    = owner_q;
    m0_done_d  = 1'b0;
    m1_done_d  = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Requester inputs are only looked at here, so they are free to change while busy.
        if (req != 2'b00) begin
          take    = 1'b1;
          owner_d = grant[1];
          if (grant[1]) begin
            s_addr_d  = m1_addr;
            s_wr_d    = m1_wr;
            s_size_d  = m1_size;
            s_wdata_d = m1_wdata;
          end else begin
            s_addr_d  = m0_addr;
            s_wr_d    = m0_wr;
            s_size_d  = m0_size;
            s_wdata_d = m0_wdata;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is routed to the latched owner even if it has since dropped its request.
        if (s_done) begin
          state_d = ST_DONE;
          if (owner_q) begin
            m1_done_d = 1'b1;
            if (!s_wr_q) m1_rdata_d = s_rdata;
          end else begin
            m0_done_d = 1'b1;
            if (!s_wr_q) m0_rdata_d = s_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      s_addr_q   <= '0;
      s_wr_q     <= 1'b0;
      s_size_q   <= 2'd0;
      s_wdata_q  <= 32'd0;
      owner_q    <= 1'b0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      s_addr_q   <= s_addr_d;
      s_wr_q     <= s_wr_d;
      s_size_q   <= s_size_d;
      s_wdata_q  <= s_wdata_d;
      owner_q    <= owner_d;
      m0_done_q  <= m0_done_d;
      m1_done_q  <= m1_done_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign s_start  = (state_q == ST_ISSUE);
  assign busy     = (state_q != ST_IDLE);
  assign s_addr   = s_addr_q;
  assign s_wr     = s_wr_q;
  assign s_size   = s_size_q;
  assign s_wdata  = s_wdata_q;
  assign owner    = owner_q;
  assign m0_done  = m0_done_q;
  assign m1_done  = m1_done_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule
